// File: rtl/exec_pkg.sv
// Shared definitions for the bf8b execute stage: opcodes, FSM states and width defaults.
package exec_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int OP_W_DEF   = 3;

  localparam int OP_NOP = 0;
  localparam int OP_LOD = 1;
  localparam int OP_STR = 2;
  localparam int OP_ADD = 3;
  localparam int OP_SUB = 4;
  localparam int OP_RMW = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU,
    S_RD,
    S_WR,
    S_DONE
  } state_e;
endpackage

// File: rtl/exec_alu.sv
// Combinational add/subtract with carry-out (add) or borrow (sub) in the top bit.
module exec_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] res,
  output logic              cout
);
  logic [DATA_W:0] ext;

  always_comb begin
    if (sub) ext = {1'b0, a} - {1'b0, b};
    else     ext = {1'b0, a} + {1'b0, b};
  end

  assign res  = ext[DATA_W-1:0];
  assign cout = ext[DATA_W];
endmodule

// File: rtl/exec_unit.sv
// Execute stage: ALU ops, load/store and atomic read-modify-write against a req/ready memory port.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] val_out,
  output logic              zero,
  output logic              carry,
  output logic              err,
  output logic              mem_req,
  output logic              we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic              mem_ready
);
  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d;
  logic [DATA_W-1:0] val_out_q, val_out_d, mem_data_out_q, mem_data_out_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic busy_q, busy_d, done_q, done_d, zero_q, zero_d, carry_q, carry_d;
  logic err_q, err_d, mem_req_q, mem_req_d, we_q, we_d;
  logic upd_val;

  logic [DATA_W-1:0] alu_a, alu_res;
  logic              alu_sub, alu_cout;

  // The adder is shared: operands in ALU, read data + increment in RD.
  always_comb begin
    alu_a   = val1_q;
    alu_sub = (op_q == OP_W'(OP_SUB));
    if (state_q == S_RD) begin
      alu_a   = mem_data_in;
      alu_sub = 1'b0;
    end
  end

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (alu_a),
    .b    (val2_q),
    .sub  (alu_sub),
    .res  (alu_res),
    .cout (alu_cout)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    val1_d         = val1_q;
    val2_d         = val2_q;
    val_out_d      = val_out_q;
    mem_data_out_d = mem_data_out_q;
    mem_addr_d     = mem_addr_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    zero_d         = zero_q;
    carry_d        = carry_q;
    mem_req_d      = mem_req_q;
    we_d           = we_q;
    upd_val        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          val1_d     = val1;
          val2_d     = val2;
          mem_addr_d = addr_in;
          busy_d     = 1'b1;
          if (op == OP_W'(OP_LOD) || op == OP_W'(OP_RMW)) begin
            state_d   = S_RD;
            mem_req_d = 1'b1;
            we_d      = 1'b0;
          end else if (op == OP_W'(OP_STR)) begin
            state_d        = S_WR;
            mem_req_d      = 1'b1;
            we_d           = 1'b1;
            mem_data_out_d = val1;
          end else begin
            state_d = S_ALU;
          end
        end
      end
      S_ALU: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        upd_val = 1'b1;
        carry_d = 1'b0;
        case (op_q)
          OP_W'(OP_ADD), OP_W'(OP_SUB): begin
            val_out_d = alu_res;
            carry_d   = alu_cout;
          end
          OP_W'(OP_NOP): val_out_d = val1_q;
          default: begin
            val_out_d = val1_q;
            err_d     = 1'b1;
          end
        endcase
      end
      S_RD: begin
        if (mem_ready) begin
          upd_val = 1'b1;
          carry_d = 1'b0;
          if (op_q == OP_W'(OP_RMW)) begin
            // Go straight into the write phase; mem_req stays asserted.
            val_out_d      = alu_res;
            mem_data_out_d = alu_res;
            we_d           = 1'b1;
            state_d        = S_WR;
          end else begin
            val_out_d = mem_data_in;
            mem_req_d = 1'b0;
            state_d   = S_DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
          end
        end
      end
      S_WR: begin
        if (mem_ready) begin
          mem_req_d      = 1'b0;
          we_d           = 1'b0;
          mem_data_out_d = '0;
          state_d        = S_DONE;
          done_d         = 1'b1;
          busy_d         = 1'b0;
          if (op_q == OP_W'(OP_STR)) begin
            upd_val   = 1'b1;
            val_out_d = val1_q;
            carry_d   = 1'b0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (upd_val) zero_d = (val_out_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= '0;
      val1_q         <= '0;
      val2_q         <= '0;
      val_out_q      <= '0;
      mem_data_out_q <= '0;
      mem_addr_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      zero_q         <= 1'b0;
      carry_q        <= 1'b0;
      mem_req_q      <= 1'b0;
      we_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      val1_q         <= val1_d;
      val2_q         <= val2_d;
      val_out_q      <= val_out_d;
      mem_data_out_q <= mem_data_out_d;
      mem_addr_q     <= mem_addr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      zero_q         <= zero_d;
      carry_q        <= carry_d;
      mem_req_q      <= mem_req_d;
      we_q           <= we_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign val_out      = val_out_q;
  assign zero         = zero_q;
  assign carry        = carry_q;
  assign err          = err_q;
  assign mem_req      = mem_req_q;
  assign we           = we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;
endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: hand-computed results for ALU, load, RMW, store, illegal op and reset abort.
module tb_exec_unit;
  logic       clk, rst, start;
  logic [2:0] op;
  logic [7:0] val1, val2, addr_in;
  logic       busy, done, zero, carry, err, mem_req, we, mem_ready;
  logic [7:0] val_out, mem_addr, mem_data_out, mem_data_in;

  int n_chk = 0;
  int n_fail = 0;
  logic cnt_clr;
  int n_wr, n_done, n_req;

  exec_unit #(.DATA_W(8), .ADDR_W(8), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .val1(val1), .val2(val2),
    .addr_in(addr_in), .busy(busy), .done(done), .val_out(val_out), .zero(zero),
    .carry(carry), .err(err), .mem_req(mem_req), .we(we), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters observed at the active edge.
  always @(posedge clk) begin
    if (cnt_clr) begin
      n_wr <= 0; n_done <= 0; n_req <= 0;
    end else begin
      if (mem_req && mem_ready && we) n_wr <= n_wr + 1;
      if (done) n_done <= n_done + 1;
      if (mem_req) n_req <= n_req + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits to the next falling edge, presents start for one cycle, returns one cycle later.
  task automatic do_start(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ad);
    @(negedge clk);
    start = 1'b1; op = o; val1 = a; val2 = b; addr_in = ad;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; val1 = '0; val2 = '0; addr_in = '0;
    mem_ready = 1'b0; mem_data_in = '0; cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_val", val_out, 0);
    check("rst_zero", zero, 0); check("rst_req", mem_req, 0); check("rst_we", we, 0);
    rst = 1'b0; cnt_clr = 1'b0;

    // ADD F0+20
    do_start(3'd3, 8'hF0, 8'h20, 8'h00);
    check("add_busy", busy, 1); check("add_done_early", done, 0);
    @(negedge clk);
    check("add_done", done, 1); check("add_busy_dn", busy, 0);
    check("add_val", val_out, 8'h10); check("add_carry", carry, 1);
    check("add_zero", zero, 0); check("add_noreq", n_req, 0);

    // SUB 5-5 then 3-4
    do_start(3'd4, 8'd5, 8'd5, 8'h00);
    @(negedge clk);
    check("sub0_done", done, 1); check("sub0_val", val_out, 0);
    check("sub0_zero", zero, 1); check("sub0_carry", carry, 0);
    do_start(3'd4, 8'd3, 8'd4, 8'h00);
    @(negedge clk);
    check("sub1_val", val_out, 8'hFF); check("sub1_carry", carry, 1); check("sub1_zero", zero, 0);

    // mem_ready while idle is ignored
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); check("idle_rdy_busy", busy, 0); check("idle_rdy_req", mem_req, 0);
    mem_ready = 1'b0;

    // LOD 3C with 3-cycle stall
    do_start(3'd1, 8'h00, 8'h00, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      check("lod_req", mem_req, 1); check("lod_we", we, 0); check("lod_done", done, 0);
      @(negedge clk);
    end
    check("lod_req4", mem_req, 1); check("lod_addr", mem_addr, 8'h3C);
    mem_ready = 1'b1; mem_data_in = 8'hA5;
    @(negedge clk);
    mem_ready = 1'b0; mem_data_in = 8'h00;
    check("lod_done", done, 1); check("lod_val", val_out, 8'hA5); check("lod_req_off", mem_req, 0);

    // RMW mem[7]=FF + 1
    do_start(3'd5, 8'h00, 8'h01, 8'h07);
    check("rmw_rd_req", mem_req, 1); check("rmw_rd_we", we, 0);
    mem_ready = 1'b1; mem_data_in = 8'hFF;
    @(negedge clk);
    mem_data_in = 8'h00;
    check("rmw_wr_req", mem_req, 1); check("rmw_wr_we", we, 1);
    check("rmw_wdata", mem_data_out, 8'h00); check("rmw_addr", mem_addr, 8'h07);
    check("rmw_done_early", done, 0);
    @(negedge clk);
    mem_ready = 1'b0;
    check("rmw_done", done, 1); check("rmw_val", val_out, 0); check("rmw_zero", zero, 1);
    check("rmw_carry", carry, 0); check("rmw_req_off", mem_req, 0); check("rmw_we_off", we, 0);

    // STR 42 with re-pulsed start
    @(negedge clk); cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    do_start(3'd2, 8'h42, 8'h00, 8'h10);
    check("str_req", mem_req, 1); check("str_we", we, 1); check("str_wdata", mem_data_out, 8'h42);
    start = 1'b1; op = 3'd3; val1 = 8'h11;
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b1;
    check("str_still_req", mem_req, 1);
    @(negedge clk);
    mem_ready = 1'b0;
    check("str_done", done, 1); check("str_val", val_out, 8'h42);
    check("str_we_off", we, 0); check("str_wdata_off", mem_data_out, 0);
    start = 1'b1; op = 3'd3;
    @(negedge clk);
    start = 1'b0;
    check("str_ign_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("str_ign_done", done, 0); check("str_nwr", n_wr, 1); check("str_ndone", n_done, 1);

    // illegal op 7
    do_start(3'd7, 8'h5A, 8'h01, 8'h00);
    @(negedge clk);
    check("ill_done", done, 1); check("ill_err", err, 1);
    check("ill_val", val_out, 8'h5A); check("ill_carry", carry, 0);
    @(negedge clk);
    check("ill_err_off", err, 0); check("ill_done_off", done, 0);

    // reset during a stalled write, then recover
    do_start(3'd2, 8'h77, 8'h00, 8'h20);
    @(negedge clk);
    check("rstwr_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstwr_req0", mem_req, 0); check("rstwr_we0", we, 0); check("rstwr_busy0", busy, 0);
    check("rstwr_done0", done, 0); check("rstwr_val0", val_out, 0);
    do_start(3'd3, 8'd1, 8'd2, 8'h00);
    @(negedge clk);
    check("post_done", done, 1); check("post_val", val_out, 8'd3); check("post_carry", carry, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
